axis_wrr_packet_arbiter: RTL



---
 rtl/axis_wrr_packet_arbiter_if.sv | 20 ++
 rtl/axis_wrr_packet_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/axis_wrr_packet_arbiter_if.sv
// AXI-Stream bundle used on both sides of the packet arbiter.
// LANES parallel streams are packed into flat vectors (lane i occupies
// tdata[i*DATA_WIDTH +: DATA_WIDTH] and tid[i*ID_WIDTH +: ID_WIDTH]).
//   tvalid : per-lane TVALID, master -> slave
//   tdata  : per-lane TDATA,  master -> slave
//   tid    : per-lane TID,    master -> slave
//   tready : per-lane TREADY, slave  -> master
interface axis_wrr_packet_arbiter_if #(
   parameter int unsigned LANES      = 1,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = 4
);
   logic [LANES-1:0]            tvalid;
   logic [LANES*DATA_WIDTH-1:0] tdata;
   logic [LANES*ID_WIDTH-1:0]   tid;
   logic [LANES-1:0]            tready;

   modport master (output tvalid, tdata, tid, input tready);
   modport slave  (input tvalid, tdata, tid, output tready);
endinterface

// File: rtl/axis_wrr_packet_arbiter.sv
// N-input, 1-output AXI-Stream packet arbiter with weighted round-robin.
// A grant is held from the routing-header beat through the last payload
// beat (count taken from the header); back-to-back packets pass without a
// bubble because the next winner is chosen on the last handshake.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   weight_i         : packets per turn per channel (0 behaves as 1)
//   in_axis          : CHANNEL_NUMBER input streams (slave side)
//   out_axis         : single output stream (master side)
//   current_grant_o  : channel currently granted
//   locked_o         : a packet is in progress
//   target_x_o/_y_o  : routing target (live header or latched copy)
//   err_o            : sticky "packet did not start with a header" flag
module axis_wrr_packet_arbiter #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ID_WIDTH       = 4,
   parameter int unsigned CHANNEL_NUMBER = 5,
   parameter int unsigned CH_W           = $clog2(CHANNEL_NUMBER),
   parameter int unsigned MAX_ROUTERS_X  = 4,
   parameter int unsigned MAX_ROUTERS_Y  = 4,
   parameter int unsigned WEIGHT_W       = 4,
   parameter int unsigned ROUTING_HEADER = 0,
   localparam int unsigned X_W = $clog2(MAX_ROUTERS_X),
   localparam int unsigned Y_W = $clog2(MAX_ROUTERS_Y)
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [CHANNEL_NUMBER*WEIGHT_W-1:0] weight_i,
   axis_wrr_packet_arbiter_if.slave           in_axis,
   axis_wrr_packet_arbiter_if.master          out_axis,
   output logic [CH_W-1:0]                    current_grant_o,
   output logic                               locked_o,
   output logic [X_W-1:0]                     target_x_o,
   output logic [Y_W-1:0]                     target_y_o,
   output logic                               err_o
);
   localparam int unsigned LEN_LSB = 2 * (X_W + Y_W);
   localparam logic [ID_WIDTH-1:0] HDR_ID = ID_WIDTH'(ROUTING_HEADER);

   typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

   state_t              state_q, state_d;
   logic [CH_W-1:0]     grant_q;
   logic [CH_W-1:0]     last_q;      // previous grant, the WRR scan origin
   logic [WEIGHT_W-1:0] credit_q [CHANNEL_NUMBER];
   logic [7:0]          remaining_q;
   logic [X_W-1:0]      tx_q;
   logic [Y_W-1:0]      ty_q;
   logic                err_q;

   logic                locked, sel_valid, hs, is_hdr, hdr_live;
   logic                keep, arb, pkt_end;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [ID_WIDTH-1:0]   sel_id;
   logic [7:0]            hdr_len;
   logic [CH_W-1:0]       win;
   logic [WEIGHT_W-1:0]   win_weight, reload;

   // Datapath: pure muxing of the granted lane keeps the output stable
   // under backpressure without any holding register.
   assign locked    = (state_q != IDLE);
   assign sel_valid = in_axis.tvalid[grant_q];
   assign sel_data  = in_axis.tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
   assign sel_id    = in_axis.tid[grant_q*ID_WIDTH +: ID_WIDTH];
   assign hs        = locked & sel_valid & out_axis.tready[0];
   assign is_hdr    = (sel_id == HDR_ID);
   assign hdr_len   = sel_data[LEN_LSB +: 8];

   assign out_axis.tvalid = locked & sel_valid;
   assign out_axis.tdata  = sel_data;
   assign out_axis.tid    = sel_id;

   always_comb begin
      in_axis.tready = '0;
      if (locked) in_axis.tready[grant_q] = out_axis.tready[0];
   end

   // WRR winner: stay on the previous grant while it still has credit,
   // otherwise scan forward from last_q+1 with last_q itself checked last.
   always_comb begin
      logic [CH_W-1:0] idx;
      logic            found;
      keep  = in_axis.tvalid[last_q] && (credit_q[last_q] > WEIGHT_W'(1));
      win   = last_q;
      found = 1'b0;
      idx   = '0;
      if (!keep) begin
         for (int unsigned k = 1; k <= CHANNEL_NUMBER; k++) begin
            idx = CH_W'((32'(last_q) + k) % CHANNEL_NUMBER);
            if (!found && in_axis.tvalid[idx]) begin
               win   = idx;
               found = 1'b1;
            end
         end
      end
   end

   assign win_weight = weight_i[win*WEIGHT_W +: WEIGHT_W];
   assign reload     = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;

   // Next state; arbitration happens from IDLE or on the last beat of a
   // packet so a waiting channel is in HEAD on the very next cycle.
   always_comb begin
      state_d = state_q;
      pkt_end = 1'b0;
      arb     = 1'b0;
      case (state_q)
         IDLE: begin
            if (|in_axis.tvalid) begin
               arb     = 1'b1;
               state_d = HEAD;
            end
         end
         HEAD: begin
            if (hs) begin
               if (!is_hdr || hdr_len == 8'd0) pkt_end = 1'b1;
               else                            state_d = BODY;
            end
         end
         BODY: begin
            if (hs && remaining_q == 8'd1) pkt_end = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (pkt_end) begin
         if (|in_axis.tvalid) begin
            arb     = 1'b1;
            state_d = HEAD;
         end else begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         last_q      <= CH_W'(CHANNEL_NUMBER - 1);
         remaining_q <= '0;
         tx_q        <= '0;
         ty_q        <= '0;
         err_q       <= 1'b0;
         for (int unsigned i = 0; i < CHANNEL_NUMBER; i++) credit_q[i] <= '0;
      end else begin
         state_q <= state_d;
         if (arb) begin
            grant_q <= win;
            last_q  <= win;
            if (keep) credit_q[win] <= credit_q[win] - WEIGHT_W'(1);
            else      credit_q[win] <= reload;
         end
         if (hs && state_q == HEAD) begin
            if (is_hdr) begin
               tx_q        <= sel_data[Y_W +: X_W];
               ty_q        <= sel_data[0 +: Y_W];
               remaining_q <= hdr_len;
            end else begin
               err_q <= 1'b1;
            end
         end else if (hs && state_q == BODY) begin
            remaining_q <= remaining_q - 8'd1;
         end
      end
   end

   assign hdr_live        = (state_q == HEAD) && sel_valid && is_hdr;
   assign target_x_o      = hdr_live ? sel_data[Y_W +: X_W] : tx_q;
   assign target_y_o      = hdr_live ? sel_data[0 +: Y_W]   : ty_q;
   assign current_grant_o = grant_q;
   assign locked_o        = locked;
   assign err_o           = err_q;
endmodule
